stream_rr_arbiter: RTL and testbench



---
 rtl/stream_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin packet arbiter that merges NUM_CH valid/ready
// streams onto one FIFO write port through a one-entry registered output stage.
// A grant is held from the first beat of a packet until its last beat (or until
// MAX_BEATS beats when that limit is enabled). Each output beat carries its
// source channel in m_id.
module stream_rr_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 64,
    parameter int ID_W      = 2,
    parameter int MAX_BEATS = 0,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH*WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]       s_valid,
    input  logic [NUM_CH-1:0]       s_last,
    output logic [NUM_CH-1:0]       s_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [ID_W-1:0]         m_id,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id
);

    // Channel inputs are widened to 2^ID_W slots so an ID_W-bit index is exact.
    localparam int NSLOT = 1 << ID_W;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [ID_W-1:0]  pick;
    logic             pick_vld;

    logic [NSLOT-1:0] vld_ext;
    logic [NSLOT-1:0] last_ext;
    logic [WIDTH-1:0] data_ext [NSLOT];

    logic             out_free;
    logic             accept;
    logic             cnt_limit;
    logic             rel;

    assign vld_ext  = NSLOT'(s_valid);
    assign last_ext = NSLOT'(s_last);

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NUM_CH) begin : g_used
            assign data_ext[i] = s_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign data_ext[i] = '0;
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free  = !m_valid || m_ready;
    assign accept    = (state == LOCKED) && vld_ext[grant_id] && out_free;
    assign cnt_limit = (MAX_BEATS != 0) && (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BEATS));
    // Grant ends on the packet's last beat or on the beat-count limit.
    assign rel       = accept && (last_ext[grant_id] || cnt_limit);

    // Round-robin pick: first valid channel scanning from rr_ptr with wrap.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!pick_vld && vld_ext[ID_W'(idx)]) begin
                pick     = ID_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: lock on any request, unlock on release.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LOCKED;
            LOCKED:  if (rel)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: only the granted channel sees ready, and only while locked.
    always_comb begin
        s_ready = '0;
        busy    = (state == LOCKED);
        if (resetn && state == LOCKED) begin
            for (int i = 0; i < NUM_CH; i++)
                s_ready[i] = (grant_id == ID_W'(i)) && out_free;
        end
    end

    // Grant bookkeeping: latch winner, count beats, advance pointer on release.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (rel)
                rr_ptr <= (grant_id == ID_W'(NUM_CH-1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // One-entry output stage: load on accept, otherwise drain on m_ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= data_ext[grant_id];
            m_last  <= last_ext[grant_id];
            m_id    <= grant_id;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter. Per-channel source queues feed the DUT;
// the expected output order is pushed to a scoreboard queue up front and every
// beat leaving the m-side is popped and compared against it.
module tb_stream_rr_arbiter;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 64;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic [NUM_CH*WIDTH-1:0] s_data = '0;
    logic [NUM_CH-1:0]       s_valid = '0;
    logic [NUM_CH-1:0]       s_last = '0;
    logic [NUM_CH-1:0]       s_ready;
    logic [WIDTH-1:0]        m_data;
    logic [ID_W-1:0]         m_id;
    logic                    m_last;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;

    beat_t             src_q [NUM_CH][$];
    exp_t              sb[$];
    logic [NUM_CH-1:0] stall = '0;
    logic [NUM_CH-1:0] acc = '0;
    logic              rn = 1'b0;
    logic              mr = 1'b1;
    logic              fired = 1'b0;
    int                n_run = 0;
    int                n_fail = 0;

    stream_rr_arbiter #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .ID_W(ID_W), .MAX_BEATS(4), .CNT_W(16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_id(m_id), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        resetn  = rn;
        m_ready = mr;
        for (int i = 0; i < NUM_CH; i++) begin
            s_valid[i] = !stall[i] && (src_q[i].size() > 0);
            s_data[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
            s_last[i] = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
        end
    endtask

    // One clock: retire last cycle's handshakes, drive, then sample at negedge.
    task automatic tick();
        exp_t e;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CH; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
        @(negedge clk);
        acc   = s_valid & s_ready;
        fired = resetn && m_valid && m_ready;
        if (fired) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("m_data", m_data, e.data);
                check("m_id",   64'(m_id), 64'(e.id));
                check("m_last", 64'(m_last), 64'(e.last));
            end
        end
    endtask

    task automatic src_pkt(input int ch, input logic [63:0] base, input int n, input logic lst);
        for (int k = 0; k < n; k++)
            src_q[ch].push_back('{data: base + 64'(k), last: lst && (k == n-1)});
    endtask

    task automatic exp_pkt(input int ch, input logic [63:0] base, input int n, input logic lst);
        for (int k = 0; k < n; k++)
            sb.push_back('{id: ID_W'(ch), data: base + 64'(k), last: lst && (k == n-1)});
    endtask

    task automatic do_reset();
        rn = 1'b0;
        mr = 1'b1;
        stall = '0;
        acc = '0;
        sb.delete();
        for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
        tick();
        tick();
        rn = 1'b1;
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        for (int k = 0; k < budget && sb.size() > 0; k++) tick();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset values.
        do_reset();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  m_data, 64'd0);
        check("rst_m_id",    64'(m_id), 64'd0);
        check("rst_m_last",  64'(m_last), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_grant",   64'(grant_id), 64'd0);

        // Single channel: ch2 sends A0..A2.
        src_pkt(2, 64'hA0, 3, 1'b1);
        exp_pkt(2, 64'hA0, 3, 1'b1);
        tick();
        check("t1_bubble_busy",  64'(busy), 64'd0);
        check("t1_bubble_ready", 64'(s_ready), 64'd0);
        tick();
        check("t1_busy",  64'(busy), 64'd1);
        check("t1_ready", 64'(s_ready), 64'b0100);
        check("t1_grant", 64'(grant_id), 64'd2);
        tick();
        check("t1_fire0", 64'(fired), 64'd1);
        tick();
        check("t1_fire1", 64'(fired), 64'd1);
        tick();
        check("t1_fire2", 64'(fired), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_rr_ptr",   64'(dut.rr_ptr), 64'd3);
        run_until_empty("t1_drain", 10);

        // Round-robin fairness: all channels valid, 2-beat packets.
        do_reset();
        src_pkt(0, 64'h100, 2, 1'b1);
        src_pkt(0, 64'h180, 2, 1'b1);
        src_pkt(1, 64'h200, 2, 1'b1);
        src_pkt(2, 64'h300, 2, 1'b1);
        src_pkt(3, 64'h400, 2, 1'b1);
        exp_pkt(0, 64'h100, 2, 1'b1);
        exp_pkt(1, 64'h200, 2, 1'b1);
        exp_pkt(2, 64'h300, 2, 1'b1);
        exp_pkt(3, 64'h400, 2, 1'b1);
        exp_pkt(0, 64'h180, 2, 1'b1);
        run_until_empty("t2_drain", 60);

        // Backpressure: m_ready low for 5 cycles while ch1 holds B1.
        do_reset();
        src_pkt(1, 64'hB0, 3, 1'b1);
        exp_pkt(1, 64'hB0, 3, 1'b1);
        tick();
        tick();
        tick();
        mr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_data",  m_data, 64'hB1);
            check("t3_hold_valid", 64'(m_valid), 64'd1);
            check("t3_hold_ready", 64'(s_ready), 64'd0);
            check("t3_hold_busy",  64'(busy), 64'd1);
        end
        mr = 1'b1;
        run_until_empty("t3_drain", 20);

        // Forced release after 4 beats; ch3 is served before ch0's remainder.
        do_reset();
        src_pkt(0, 64'hC0, 6, 1'b0);
        src_pkt(3, 64'hD0, 2, 1'b1);
        exp_pkt(0, 64'hC0, 4, 1'b0);
        exp_pkt(3, 64'hD0, 2, 1'b1);
        exp_pkt(0, 64'hC4, 2, 1'b0);
        run_until_empty("t4_drain", 40);

        // Reset during beat 2 of a ch1 packet.
        do_reset();
        src_pkt(1, 64'hE0, 3, 1'b1);
        sb.push_back('{id: ID_W'(1), data: 64'hE0, last: 1'b0});
        tick();
        tick();
        tick();
        rn = 1'b0;
        tick();
        check("t5_rst_ready", 64'(s_ready), 64'd0);
        rn = 1'b1;
        src_q[1].delete();
        tick();
        check("t5_m_valid", 64'(m_valid), 64'd0);
        check("t5_s_ready", 64'(s_ready), 64'd0);
        check("t5_busy",    64'(busy), 64'd0);
        check("t5_rr_ptr",  64'(dut.rr_ptr), 64'd0);
        check("t5_grant",   64'(grant_id), 64'd0);
        check("t5_sb_e0",   64'(sb.size()), 64'd0);
        src_pkt(1, 64'h51, 1, 1'b1);
        src_pkt(0, 64'h50, 1, 1'b1);
        exp_pkt(0, 64'h50, 1, 1'b1);
        exp_pkt(1, 64'h51, 1, 1'b1);
        run_until_empty("t5_drain", 20);

        // Wrap and stall: ch3 stalls mid-packet while ch0 waits.
        do_reset();
        src_pkt(3, 64'hF0, 3, 1'b1);
        exp_pkt(3, 64'hF0, 3, 1'b1);
        exp_pkt(0, 64'h60, 1, 1'b1);
        tick();
        tick();
        stall[3] = 1'b1;
        src_pkt(0, 64'h60, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_stall_ready", 64'(s_ready), 64'b1000);
            check("t6_stall_grant", 64'(grant_id), 64'd3);
            check("t6_stall_busy",  64'(busy), 64'd1);
        end
        stall[3] = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick();
        check("t6_released", 64'(busy), 64'd0);
        check("t6_rr_wrap",  64'(dut.rr_ptr), 64'd0);
        run_until_empty("t6_drain", 20);
        check("t6_grant_ch0", 64'(grant_id), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
